bist_controller: RTL and testbench

- Sequencer for the s9234 logic-BIST wrapper. Drives TPG reset, bist_en and scan_en through init/shift/capture/unload phases.
- Compacts the 7 scan-out chains into an internal 7-bit MISR.
- Compares the final signature with a golden value and reports done/pass.
- Sits beside the wrapper; its outputs connect straight to the wrapper's scan_en, bist_en and TPG_reset pins.

---
 rtl/bist_controller.sv | 212 +++++++++++++++++++++
 tb/tb_bist_controller.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bist_controller.sv
// Logic-BIST sequencer for the s9234 wrapper: drives TPG reset, bist_en and scan_en, compacts scan-out into a 7-bit MISR.
// Optional macro BIST_ABORT_EN adds an 'abort' input that ends a run early with pass forced low.
module bist_controller #(
    parameter int          CHAIN_LEN    = 33,
    parameter int          NUM_PATTERNS = 256,
    parameter int          CNT_W        = 16,
    parameter logic [6:0]  GOLDEN_SIG   = 7'h00
) (
    input  logic             CK,
    input  logic             reset_n,
    input  logic             start,
`ifdef BIST_ABORT_EN
    input  logic             abort,
`endif
    input  logic [6:0]       so_chain,
    output logic             scan_en,
    output logic             bist_en,
    output logic             tpg_reset,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [6:0]       signature,
    output logic [CNT_W-1:0] pattern_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_SHIFT,
        ST_CAPTURE,
        ST_UNLOAD,
        ST_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] PAT_MAX    = CNT_W'(NUM_PATTERNS);

    // Parameter sanity checks fire at elaboration; they produce no hardware.
    if (CHAIN_LEN < 1) begin : g_bad_chain_len
        $fatal(1, "bist_controller: CHAIN_LEN must be >= 1");
    end
    if (NUM_PATTERNS < 1) begin : g_bad_num_patterns
        $fatal(1, "bist_controller: NUM_PATTERNS must be >= 1");
    end
    if (longint'(NUM_PATTERNS) >= (longint'(1) << CNT_W)) begin : g_bad_cnt_w
        $fatal(1, "bist_controller: NUM_PATTERNS must be < 2**CNT_W");
    end
    if (longint'(CHAIN_LEN) > (longint'(1) << CNT_W)) begin : g_bad_shift_w
        $fatal(1, "bist_controller: CHAIN_LEN does not fit the shift counter");
    end

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   shift_cnt_q, shift_cnt_d;
    logic [CNT_W-1:0]   pattern_cnt_q, pattern_cnt_d;
    logic [6:0]         misr_q, misr_d;
    logic               pass_q, pass_d;
    logic               scan_en_q, scan_en_d;
    logic               bist_en_q, bist_en_d;
    logic               tpg_reset_q, tpg_reset_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [6:0]         misr_upd;
    logic               shift_last;
    logic               pattern_last;

    // MISR feedback polynomial x^7 + x^6 + 1
    assign misr_upd = {misr_q[5] ^ misr_q[6] ^ so_chain[6],
                       misr_q[4:0] ^ so_chain[5:1],
                       misr_q[6] ^ so_chain[0]};

    assign shift_last   = (shift_cnt_q == SHIFT_LAST);
    assign pattern_last = ((pattern_cnt_q + CNT_ONE) == PAT_MAX);

    always_comb begin
        state_d       = state_q;
        shift_cnt_d   = shift_cnt_q;
        pattern_cnt_d = pattern_cnt_q;
        misr_d        = misr_q;
        pass_d        = pass_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d       = ST_INIT;
                    shift_cnt_d   = '0;
                    pattern_cnt_d = '0;
                    misr_d        = '0;
                    pass_d        = 1'b0;
                end
            end
            ST_INIT: begin
                state_d       = ST_SHIFT;
                shift_cnt_d   = '0;
                pattern_cnt_d = '0;
                misr_d        = '0;
            end
            ST_SHIFT: begin
                // The first load only flushes unknown chain contents, so it is not compacted.
                if (pattern_cnt_q != '0) begin
                    misr_d = misr_upd;
                end
                if (shift_last) begin
                    shift_cnt_d = '0;
                    state_d     = ST_CAPTURE;
                end else begin
                    shift_cnt_d = shift_cnt_q + CNT_ONE;
                end
            end
            ST_CAPTURE: begin
                if (pattern_cnt_q != PAT_MAX) begin
                    pattern_cnt_d = pattern_cnt_q + CNT_ONE;
                end
                state_d = pattern_last ? ST_UNLOAD : ST_SHIFT;
            end
            ST_UNLOAD: begin
                misr_d = misr_upd;
                if (shift_last) begin
                    shift_cnt_d = '0;
                    state_d     = ST_DONE;
                    pass_d      = (misr_upd == GOLDEN_SIG);
                end else begin
                    shift_cnt_d = shift_cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef BIST_ABORT_EN
        // Abort freezes signature and pattern count so a failing run can be inspected.
        if (abort && (state_q == ST_INIT || state_q == ST_SHIFT ||
                      state_q == ST_CAPTURE || state_q == ST_UNLOAD)) begin
            state_d       = ST_DONE;
            shift_cnt_d   = '0;
            pattern_cnt_d = pattern_cnt_q;
            misr_d        = misr_q;
            pass_d        = 1'b0;
        end
`endif
    end

    // Outputs are decoded from the next state and registered so they line up with state_q.
    always_comb begin
        scan_en_d   = 1'b0;
        bist_en_d   = 1'b0;
        tpg_reset_d = 1'b1;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        case (state_d)
            ST_INIT: begin
                scan_en_d   = 1'b1;
                bist_en_d   = 1'b1;
                busy_d      = 1'b1;
            end
            ST_SHIFT, ST_UNLOAD: begin
                scan_en_d   = 1'b1;
                bist_en_d   = 1'b1;
                tpg_reset_d = 1'b0;
                busy_d      = 1'b1;
            end
            ST_CAPTURE: begin
                bist_en_d   = 1'b1;
                tpg_reset_d = 1'b0;
                busy_d      = 1'b1;
            end
            ST_DONE: begin
                done_d      = 1'b1;
            end
            default: begin
                tpg_reset_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CK or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            shift_cnt_q   <= '0;
            pattern_cnt_q <= '0;
            misr_q        <= '0;
            pass_q        <= 1'b0;
            scan_en_q     <= 1'b0;
            bist_en_q     <= 1'b0;
            tpg_reset_q   <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_cnt_q   <= shift_cnt_d;
            pattern_cnt_q <= pattern_cnt_d;
            misr_q        <= misr_d;
            pass_q        <= pass_d;
            scan_en_q     <= scan_en_d;
            bist_en_q     <= bist_en_d;
            tpg_reset_q   <= tpg_reset_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign scan_en     = scan_en_q;
    assign bist_en     = bist_en_q;
    assign tpg_reset   = tpg_reset_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign signature   = misr_q;
    assign pattern_cnt = pattern_cnt_q;

endmodule

// File: tb/tb_bist_controller.sv
// Directed bench for bist_controller: two instances (CHAIN_LEN=4 with NUM_PATTERNS=2 and 1) sharing clock and reset.
module tb_bist_controller;

    logic        CK = 1'b0;
    logic        resetN;
    logic        startA, startB;
    logic [6:0]  soA, soB;
`ifdef BIST_ABORT_EN
    logic        abortA, abortB;
`endif
    logic        scanEnA, bistEnA, tpgResetA, busyA, doneA, passA;
    logic        scanEnB, bistEnB, tpgResetB, busyB, doneB, passB;
    logic [6:0]  sigA, sigB;
    logic [15:0] patCntA, patCntB;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 CK = ~CK;

    bist_controller #(.CHAIN_LEN(4), .NUM_PATTERNS(2), .CNT_W(16), .GOLDEN_SIG(7'h00)) dutA (
        .CK(CK), .reset_n(resetN), .start(startA),
`ifdef BIST_ABORT_EN
        .abort(abortA),
`endif
        .so_chain(soA), .scan_en(scanEnA), .bist_en(bistEnA), .tpg_reset(tpgResetA),
        .busy(busyA), .done(doneA), .pass(passA), .signature(sigA), .pattern_cnt(patCntA)
    );

    bist_controller #(.CHAIN_LEN(4), .NUM_PATTERNS(1), .CNT_W(16), .GOLDEN_SIG(7'h55)) dutB (
        .CK(CK), .reset_n(resetN), .start(startB),
`ifdef BIST_ABORT_EN
        .abort(abortB),
`endif
        .so_chain(soB), .scan_en(scanEnB), .bist_en(bistEnB), .tpg_reset(tpgResetB),
        .busy(busyB), .done(doneB), .pass(passB), .signature(sigB), .pattern_cnt(patCntB)
    );

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        startA = 1'b0; startB = 1'b0;
        soA = 7'h00;   soB = 7'h00;
`ifdef BIST_ABORT_EN
        abortA = 1'b0; abortB = 1'b0;
`endif
        #12;
        testsRun++; if (scanEnA !== 1'b0)   begin testsFailed++; $display("[TB] FAIL reset_scan_en got %b want 0", scanEnA); end
        testsRun++; if (bistEnA !== 1'b0)   begin testsFailed++; $display("[TB] FAIL reset_bist_en got %b want 0", bistEnA); end
        testsRun++; if (tpgResetA !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_tpg_reset got %b want 1", tpgResetA); end
        testsRun++; if (busyA !== 1'b0)     begin testsFailed++; $display("[TB] FAIL reset_busy got %b want 0", busyA); end
        testsRun++; if (doneA !== 1'b0)     begin testsFailed++; $display("[TB] FAIL reset_done got %b want 0", doneA); end
        testsRun++; if (passA !== 1'b0)     begin testsFailed++; $display("[TB] FAIL reset_pass got %b want 0", passA); end
        testsRun++; if (sigA !== 7'h00)     begin testsFailed++; $display("[TB] FAIL reset_signature got %h want 00", sigA); end
        testsRun++; if (patCntA !== 16'd0)  begin testsFailed++; $display("[TB] FAIL reset_pattern_cnt got %0d want 0", patCntA); end
        @(negedge CK);
        resetN = 1'b1;
        tick();
    endtask

    task automatic test_idle_hold();
        repeat (20) tick();
        testsRun++; if (busyA !== 1'b0)     begin testsFailed++; $display("[TB] FAIL idle_busy got %b want 0", busyA); end
        testsRun++; if (doneA !== 1'b0)     begin testsFailed++; $display("[TB] FAIL idle_done got %b want 0", doneA); end
        testsRun++; if (tpgResetA !== 1'b1) begin testsFailed++; $display("[TB] FAIL idle_tpg_reset got %b want 1", tpgResetA); end
        testsRun++; if (bistEnA !== 1'b0)   begin testsFailed++; $display("[TB] FAIL idle_bist_en got %b want 0", bistEnA); end
    endtask

    task automatic test_sequence();
        // Cycles 1..14 after INIT: shift x4, capture, shift x4, capture, unload x4 (bit k-1 = cycle k).
        logic [13:0] expScan = 14'b1111_0_1111_0_1111;
        startA = 1'b1;
        tick();
        startA = 1'b0;
        testsRun++; if (busyA !== 1'b1)     begin testsFailed++; $display("[TB] FAIL init_busy got %b want 1", busyA); end
        testsRun++; if (bistEnA !== 1'b1)   begin testsFailed++; $display("[TB] FAIL init_bist_en got %b want 1", bistEnA); end
        testsRun++; if (scanEnA !== 1'b1)   begin testsFailed++; $display("[TB] FAIL init_scan_en got %b want 1", scanEnA); end
        testsRun++; if (tpgResetA !== 1'b1) begin testsFailed++; $display("[TB] FAIL init_tpg_reset got %b want 1", tpgResetA); end
        for (int k = 1; k <= 14; k++) begin
            tick();
            testsRun++; if (scanEnA !== expScan[k-1]) begin testsFailed++; $display("[TB] FAIL seq_scan_en_c%0d got %b want %b", k, scanEnA, expScan[k-1]); end
            testsRun++; if (tpgResetA !== 1'b0) begin testsFailed++; $display("[TB] FAIL seq_tpg_reset_c%0d got %b want 0", k, tpgResetA); end
            testsRun++; if (doneA !== 1'b0)     begin testsFailed++; $display("[TB] FAIL seq_done_c%0d got %b want 0", k, doneA); end
        end
        tick();
        testsRun++; if (doneA !== 1'b1)     begin testsFailed++; $display("[TB] FAIL seq_done_c15 got %b want 1", doneA); end
        testsRun++; if (busyA !== 1'b0)     begin testsFailed++; $display("[TB] FAIL seq_busy_c15 got %b want 0", busyA); end
        testsRun++; if (patCntA !== 16'd2)  begin testsFailed++; $display("[TB] FAIL seq_pattern_cnt got %0d want 2", patCntA); end
        testsRun++; if (sigA !== 7'h00)     begin testsFailed++; $display("[TB] FAIL seq_signature got %h want 00", sigA); end
        testsRun++; if (passA !== 1'b1)     begin testsFailed++; $display("[TB] FAIL seq_pass got %b want 1", passA); end
        testsRun++; if (bistEnA !== 1'b0)   begin testsFailed++; $display("[TB] FAIL seq_done_bist_en got %b want 0", bistEnA); end
        testsRun++; if (tpgResetA !== 1'b1) begin testsFailed++; $display("[TB] FAIL seq_done_tpg_reset got %b want 1", tpgResetA); end
    endtask

    task automatic test_misr_math();
        startA = 1'b1;
        tick();
        startA = 1'b0;
        testsRun++; if (doneA !== 1'b0)    begin testsFailed++; $display("[TB] FAIL restart_done got %b want 0", doneA); end
        testsRun++; if (passA !== 1'b0)    begin testsFailed++; $display("[TB] FAIL restart_pass got %b want 0", passA); end
        testsRun++; if (patCntA !== 16'd0) begin testsFailed++; $display("[TB] FAIL restart_pattern_cnt got %0d want 0", patCntA); end
        repeat (6) tick();
        testsRun++; if (patCntA !== 16'd1) begin testsFailed++; $display("[TB] FAIL misr_pattern_cnt got %0d want 1", patCntA); end
        soA = 7'h01;
        tick();
        testsRun++; if (sigA !== 7'h01)    begin testsFailed++; $display("[TB] FAIL misr_step1 got %h want 01", sigA); end
        soA = 7'h00;
        tick();
        testsRun++; if (sigA !== 7'h02)    begin testsFailed++; $display("[TB] FAIL misr_step2 got %h want 02", sigA); end
        repeat (7) tick();
        // 02 -> 04 -> 08 | capture | 10 -> 20 -> 40 -> 41 (feedback from bit 6)
        testsRun++; if (doneA !== 1'b1)    begin testsFailed++; $display("[TB] FAIL misr_done got %b want 1", doneA); end
        testsRun++; if (sigA !== 7'h41)    begin testsFailed++; $display("[TB] FAIL misr_final got %h want 41", sigA); end
        testsRun++; if (passA !== 1'b0)    begin testsFailed++; $display("[TB] FAIL misr_pass got %b want 0", passA); end
    endtask

    task automatic test_first_load();
        startB = 1'b1;
        tick();
        startB = 1'b0;
        tick();
        soB = 7'h7F;
        tick();
        tick();
        startB = 1'b1;
        tick();
        tick();
        soB = 7'h00;
        tick();
        startB = 1'b0;
        testsRun++; if (busyB !== 1'b1)    begin testsFailed++; $display("[TB] FAIL busy_start_ignored got %b want 1", busyB); end
        testsRun++; if (patCntB !== 16'd1) begin testsFailed++; $display("[TB] FAIL unload_pattern_cnt got %0d want 1", patCntB); end
        repeat (4) tick();
        testsRun++; if (doneB !== 1'b1)    begin testsFailed++; $display("[TB] FAIL mask_done got %b want 1", doneB); end
        testsRun++; if (sigB !== 7'h00)    begin testsFailed++; $display("[TB] FAIL mask_signature got %h want 00", sigB); end
        testsRun++; if (passB !== 1'b0)    begin testsFailed++; $display("[TB] FAIL mask_pass got %b want 0", passB); end
        tick();
        testsRun++; if (doneB !== 1'b1)    begin testsFailed++; $display("[TB] FAIL done_hold got %b want 1", doneB); end
        testsRun++; if (patCntB !== 16'd1) begin testsFailed++; $display("[TB] FAIL done_hold_cnt got %0d want 1", patCntB); end
    endtask

    task automatic test_golden_mismatch();
        startB = 1'b1;
        tick();
        startB = 1'b0;
        testsRun++; if (doneB !== 1'b0)    begin testsFailed++; $display("[TB] FAIL gold_restart_done got %b want 0", doneB); end
        testsRun++; if (patCntB !== 16'd0) begin testsFailed++; $display("[TB] FAIL gold_restart_cnt got %0d want 0", patCntB); end
        repeat (10) tick();
        testsRun++; if (doneB !== 1'b1)    begin testsFailed++; $display("[TB] FAIL gold_done got %b want 1", doneB); end
        testsRun++; if (sigB !== 7'h00)    begin testsFailed++; $display("[TB] FAIL gold_signature got %h want 00", sigB); end
        testsRun++; if (passB !== 1'b0)    begin testsFailed++; $display("[TB] FAIL gold_pass got %b want 0", passB); end
    endtask

`ifdef BIST_ABORT_EN
    task automatic test_abort();
        startA = 1'b1;
        tick();
        startA = 1'b0;
        repeat (8) tick();
        abortA = 1'b1;
        tick();
        abortA = 1'b0;
        testsRun++; if (doneA !== 1'b1)    begin testsFailed++; $display("[TB] FAIL abort_done got %b want 1", doneA); end
        testsRun++; if (busyA !== 1'b0)    begin testsFailed++; $display("[TB] FAIL abort_busy got %b want 0", busyA); end
        testsRun++; if (passA !== 1'b0)    begin testsFailed++; $display("[TB] FAIL abort_pass got %b want 0", passA); end
        testsRun++; if (patCntA !== 16'd1) begin testsFailed++; $display("[TB] FAIL abort_pattern_cnt got %0d want 1", patCntA); end
    endtask
`endif

    task automatic test_reset_mid_run();
        startA = 1'b1;
        tick();
        startA = 1'b0;
        repeat (6) tick();
        soA = 7'h01;
        tick();
        soA = 7'h00;
        testsRun++; if (sigA !== 7'h01)     begin testsFailed++; $display("[TB] FAIL pre_reset_signature got %h want 01", sigA); end
        #2;
        resetN = 1'b0;
        #1;
        testsRun++; if (scanEnA !== 1'b0)   begin testsFailed++; $display("[TB] FAIL midrst_scan_en got %b want 0", scanEnA); end
        testsRun++; if (tpgResetA !== 1'b1) begin testsFailed++; $display("[TB] FAIL midrst_tpg_reset got %b want 1", tpgResetA); end
        testsRun++; if (busyA !== 1'b0)     begin testsFailed++; $display("[TB] FAIL midrst_busy got %b want 0", busyA); end
        testsRun++; if (sigA !== 7'h00)     begin testsFailed++; $display("[TB] FAIL midrst_signature got %h want 00", sigA); end
        testsRun++; if (patCntA !== 16'd0)  begin testsFailed++; $display("[TB] FAIL midrst_pattern_cnt got %0d want 0", patCntA); end
        @(negedge CK);
        resetN = 1'b1;
        repeat (3) tick();
        testsRun++; if (busyA !== 1'b0)     begin testsFailed++; $display("[TB] FAIL post_reset_busy got %b want 0", busyA); end
    endtask

    initial begin
        test_reset();
        test_idle_hold();
        test_sequence();
        test_misr_math();
        test_first_load();
        test_golden_mismatch();
`ifdef BIST_ABORT_EN
        test_abort();
`endif
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
